// File: rtl/servo_ramp_pwm.sv
// servo_ramp_pwm: N-channel hobby-servo PWM generator with per-frame angle slewing.
// Targets are 16.16 fixed-point degrees clamped to 180. Once per frame each
// channel's current angle moves toward its target by at most STEP. The new
// angle is converted to a pulse width, and that width is shown on the pins
// from the following frame.
// Optional build macro SERVO_RDBK_EN adds a registered current-angle readback
// port (rd_ch / rd_angle).
module servo_ramp_pwm #(
  parameter int          CH        = 4,
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          PERIOD_US = 20000,
  parameter int          MIN_US    = 500,
  parameter int          MAX_US    = 2500,
  parameter logic [31:0] STEP      = 32'h0001_0000,
  parameter logic [31:0] HOME      = 32'h005A_0000,
  localparam int         CW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [31:0]   wr_angle,
`ifdef SERVO_RDBK_EN
  input  logic [CW-1:0] rd_ch,
  output logic [31:0]   rd_angle,
`endif
  output logic [CH-1:0] pwm,
  output logic [CH-1:0] busy,
  output logic          frame_tick
);

  localparam int          TPU          = CLK_HZ / 1_000_000;
  localparam int          PERIOD_TICKS = PERIOD_US * TPU;
  localparam int          MIN_TICKS    = MIN_US * TPU;
  localparam int          SPAN_TICKS   = (MAX_US - MIN_US) * TPU;
  localparam logic [31:0] A180         = 32'h00B4_0000;
  localparam int          CNT_W        = $clog2(PERIOD_TICKS + 1);

  // Exact angle-to-ticks conversion; the 64-bit product cannot overflow for a <= 180 deg.
  function automatic logic [CNT_W-1:0] width_of(input logic [31:0] a);
    logic [63:0] scaled;
    scaled = (64'(a) * 64'(SPAN_TICKS)) / 64'(A180);
    return CNT_W'(scaled + 64'(MIN_TICKS));
  endfunction

  localparam logic [CNT_W-1:0] HOME_W = width_of(HOME);

  typedef enum logic {ST_RUN, ST_UPDATE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 frame_tick_reg;
  logic                 wrap;
  logic                 upd_en;

  logic [CH-1:0][31:0]  cur_all;
  logic [CH-1:0][31:0]  tgt_all;
  logic [31:0]          cur_sel;
  logic [31:0]          tgt_sel;
  logic [31:0]          ramp_next;
  logic [CNT_W-1:0]     width_upd;
  logic [31:0]          wr_clamped;

  // Frame counter and state register; en low parks everything at a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      frame_tick_reg <= wrap;
    end
  end

  // Next-state logic: wrap starts an UPDATE sweep that visits one channel per cycle.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    wrap       = 1'b0;
    upd_en     = 1'b0;
    if (!en) begin
      cnt_next   = '0;
      state_next = ST_RUN;
      idx_next   = '0;
    end else begin
      if (cnt_reg == CNT_W'(PERIOD_TICKS - 1)) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      case (state_reg)
        ST_RUN: begin
          if (wrap) begin
            state_next = ST_UPDATE;
            idx_next   = '0;
          end
        end
        ST_UPDATE: begin
          upd_en = 1'b1;
          if (idx_reg == CW'(CH - 1)) begin
            state_next = ST_RUN;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  assign cur_sel    = cur_all[idx_reg];
  assign tgt_sel    = tgt_all[idx_reg];
  assign wr_clamped = (wr_angle > A180) ? A180 : wr_angle;

  // Bounded slew for the channel being visited; one shared converter serves all channels.
  always_comb begin
    ramp_next = tgt_sel;
    if (tgt_sel > cur_sel) begin
      if ((STEP != 32'd0) && ((tgt_sel - cur_sel) > STEP))
        ramp_next = cur_sel + STEP;
    end else begin
      if ((STEP != 32'd0) && ((cur_sel - tgt_sel) > STEP))
        ramp_next = cur_sel - STEP;
    end
  end

  assign width_upd = width_of(ramp_next);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [31:0]      tgt_reg;
      logic [31:0]      cur_reg;
      logic [CNT_W-1:0] wnext_reg;
      logic [CNT_W-1:0] wact_reg;
      logic             pwm_reg;
      logic             busy_reg;
      logic             upd_sel;

      assign upd_sel = upd_en && (idx_reg == CW'(gi));

      // Per-channel target, slewed angle, double-buffered width and pin register.
      always_ff @(posedge clk) begin
        if (rst) begin
          tgt_reg   <= HOME;
          cur_reg   <= HOME;
          wnext_reg <= HOME_W;
          wact_reg  <= HOME_W;
          pwm_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end else begin
          if (wr_en && (wr_ch == CW'(gi)))
            tgt_reg <= wr_clamped;
          if (upd_sel) begin
            cur_reg   <= ramp_next;
            wnext_reg <= width_upd;
          end
          if (wrap)
            wact_reg <= wnext_reg;
          pwm_reg  <= en && (cnt_reg < wact_reg);
          busy_reg <= (cur_reg != tgt_reg);
        end
      end

      assign cur_all[gi] = cur_reg;
      assign tgt_all[gi] = tgt_reg;
      assign pwm[gi]     = pwm_reg;
      assign busy[gi]    = busy_reg;
    end
  endgenerate

  assign frame_tick = frame_tick_reg;

`ifdef SERVO_RDBK_EN
  logic [31:0] rd_angle_reg;

  // Registered readback of the slewed angle; out-of-range channels read as zero.
  always_ff @(posedge clk) begin
    if (rst)
      rd_angle_reg <= 32'd0;
    else if ({1'b0, rd_ch} < (CW + 1)'(CH))
      rd_angle_reg <= cur_all[rd_ch];
    else
      rd_angle_reg <= 32'd0;
  end

  assign rd_angle = rd_angle_reg;
`endif

endmodule
